uart_alu_cmd_ctrl: RTL and testbench

Command sequencer between a byte-wide UART RX/TX pair and a combinational ALU, generalised to multi-byte operands.
- Receives an opcode byte, then operand A, then operand B (each DATA_WIDTH bits, LSB byte first).
- Drives the ALU, registers the result and returns it over UART TX, LSB byte first.
- Adds opcode validation, an inter-byte timeout and status outputs.

---
 rtl/uart_alu_cmd_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_alu_cmd_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_cmd_ctrl.sv
// UART command sequencer: opcode + multi-byte operands in, ALU result bytes out (LSB first).
// Optional checksum framing on both directions when UART_ALU_CHECKSUM_EN is defined.
module uart_alu_cmd_ctrl #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         TIMEOUT_CLKS = 2_604_000,
    parameter logic [7:0] ERR_CODE     = 8'hEE
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [5:0]            o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_busy,
    output logic                  o_err_op,
    output logic                  o_timeout
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [2:0] NB_LAST = 3'(NB - 1);
`ifdef UART_ALU_CHECKSUM_EN
    localparam logic [2:0] RES_LEN = 3'(NB + 1);
    localparam logic [2:0] ERR_LEN = 3'd2;
`else
    localparam logic [2:0] RES_LEN = 3'(NB);
    localparam logic [2:0] ERR_LEN = 3'd1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        RX_CHK,
        EXEC,
        TX_START,
        TX_WAIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic [2:0]              len_reg, len_next;
    logic [TO_W-1:0]         to_cnt_reg, to_cnt_next;
    logic [DATA_WIDTH-1:0]   result_reg, result_next;
    logic [7:0]              tx_data_reg, tx_data_next;
    logic [DATA_WIDTH-1:0]   alu_a_reg, alu_a_next;
    logic [DATA_WIDTH-1:0]   alu_b_reg, alu_b_next;
    logic [5:0]              alu_op_reg, alu_op_next;
    logic                    err_op_reg, err_op_next;
    logic                    timeout_reg, timeout_next;
`ifdef UART_ALU_CHECKSUM_EN
    logic [7:0]              rx_xor_reg, rx_xor_next;
    logic [7:0]              tx_xor_reg, tx_xor_next;
`endif

    logic [7:0] result_byte [NB];
    logic [2:0] tx_idx;
    logic [7:0] tx_byte;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_result_bytes
            assign result_byte[gi] = result_reg[8*gi +: 8];
        end
    endgenerate

    function automatic logic opcode_valid(input logic [7:0] b);
        case (b)
            8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        to_cnt_next  = to_cnt_reg;
        result_next  = result_reg;
        tx_data_next = tx_data_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        alu_op_next  = alu_op_reg;
        err_op_next  = 1'b0;
        timeout_next = 1'b0;
`ifdef UART_ALU_CHECKSUM_EN
        rx_xor_next  = rx_xor_reg;
        tx_xor_next  = tx_xor_reg;
`endif

        // Byte that follows the one currently on the wire
        tx_idx  = cnt_reg + 3'd1;
        tx_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (tx_idx == 3'(i)) tx_byte = result_byte[i];
        end
`ifdef UART_ALU_CHECKSUM_EN
        if (tx_idx == len_reg - 3'd1) tx_byte = tx_xor_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (i_rx_done) begin
                    cnt_next = '0;
                    if (opcode_valid(i_rx_data)) begin
                        alu_op_next = i_rx_data[5:0];
                        to_cnt_next = '0;
                        state_next  = RX_A;
`ifdef UART_ALU_CHECKSUM_EN
                        rx_xor_next = i_rx_data;
`endif
                    end else begin
                        err_op_next  = 1'b1;
                        tx_data_next = ERR_CODE;
                        len_next     = ERR_LEN;
                        state_next   = TX_START;
`ifdef UART_ALU_CHECKSUM_EN
                        tx_xor_next  = '0;
`endif
                    end
                end
            end
            RX_A, RX_B, RX_CHK: begin
                if (i_rx_done) begin
                    // A received byte beats a simultaneous timeout expiry
                    to_cnt_next = '0;
`ifdef UART_ALU_CHECKSUM_EN
                    rx_xor_next = rx_xor_reg ^ i_rx_data;
`endif
                    if (state_reg == RX_A) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cnt_reg == 3'(i)) alu_a_next[8*i +: 8] = i_rx_data;
                        end
                        if (cnt_reg == NB_LAST) begin
                            cnt_next   = '0;
                            state_next = RX_B;
                        end else begin
                            cnt_next = cnt_reg + 3'd1;
                        end
                    end else if (state_reg == RX_B) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cnt_reg == 3'(i)) alu_b_next[8*i +: 8] = i_rx_data;
                        end
                        if (cnt_reg == NB_LAST) begin
                            cnt_next = '0;
`ifdef UART_ALU_CHECKSUM_EN
                            state_next = RX_CHK;
`else
                            state_next = EXEC;
`endif
                        end else begin
                            cnt_next = cnt_reg + 3'd1;
                        end
                    end
`ifdef UART_ALU_CHECKSUM_EN
                    else begin
                        if (i_rx_data == rx_xor_reg) begin
                            state_next = EXEC;
                        end else begin
                            err_op_next  = 1'b1;
                            tx_data_next = ERR_CODE;
                            len_next     = ERR_LEN;
                            cnt_next     = '0;
                            tx_xor_next  = '0;
                            state_next   = TX_START;
                        end
                    end
`endif
                end else if (to_cnt_reg == TO_LAST) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
                    to_cnt_next  = '0;
                    state_next   = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            EXEC: begin
                result_next  = i_alu_result;
                tx_data_next = i_alu_result[7:0];
                len_next     = RES_LEN;
                cnt_next     = '0;
                state_next   = TX_START;
`ifdef UART_ALU_CHECKSUM_EN
                tx_xor_next  = '0;
`endif
            end
            TX_START: begin
`ifdef UART_ALU_CHECKSUM_EN
                tx_xor_next = tx_xor_reg ^ tx_data_reg;
`endif
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (tx_idx < len_reg) begin
                        cnt_next     = tx_idx;
                        tx_data_next = tx_byte;
                        state_next   = TX_START;
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            to_cnt_reg  <= '0;
            result_reg  <= '0;
            tx_data_reg <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
            err_op_reg  <= 1'b0;
            timeout_reg <= 1'b0;
`ifdef UART_ALU_CHECKSUM_EN
            rx_xor_reg  <= '0;
            tx_xor_reg  <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            to_cnt_reg  <= to_cnt_next;
            result_reg  <= result_next;
            tx_data_reg <= tx_data_next;
            alu_a_reg   <= alu_a_next;
            alu_b_reg   <= alu_b_next;
            alu_op_reg  <= alu_op_next;
            err_op_reg  <= err_op_next;
            timeout_reg <= timeout_next;
`ifdef UART_ALU_CHECKSUM_EN
            rx_xor_reg  <= rx_xor_next;
            tx_xor_reg  <= tx_xor_next;
`endif
        end
    end

    assign o_tx_start = (state_reg == TX_START);
    assign o_tx_data  = tx_data_reg;
    assign o_alu_a    = alu_a_reg;
    assign o_alu_b    = alu_b_reg;
    assign o_alu_op   = alu_op_reg;
    assign o_busy     = (state_reg != IDLE);
    assign o_err_op   = err_op_reg;
    assign o_timeout  = timeout_reg;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// Self-checking bench for uart_alu_cmd_ctrl: an 8-bit and a 16-bit instance, scoreboarded TX bytes.
module tb_uart_alu_cmd_ctrl;

    localparam int TX_GAP  = 4;
    localparam int TO_CLKS = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rx_done8 = 1'b0, tx_done8 = 1'b0;
    logic [7:0] rx_data8 = 8'h00;
    logic       tx_start8, busy8, err_op8, timeout8;
    logic [7:0] tx_data8, alu_a8, alu_b8, alu_res8;
    logic [5:0] alu_op8;

    logic        rx_done16 = 1'b0, tx_done16 = 1'b0;
    logic [7:0]  rx_data16 = 8'h00;
    logic        tx_start16, busy16, err_op16, timeout16;
    logic [7:0]  tx_data16;
    logic [15:0] alu_a16, alu_b16, alu_res16;
    logic [5:0]  alu_op16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cnt8 = 0, cnt16 = 0;
    int last8 = -1000, last16 = -1000;
    int to_seen8 = 0;
    logic [7:0] e8, e16;
    logic [7:0] exp8[$];
    logic [7:0] exp16[$];

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [31:0] mask, r;
        logic signed [31:0] sa;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sa = signed'(a << (32 - w)) >>> (32 - w);
        case (op)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b;
            6'h03: r = sa >>> b;
            default: r = 32'd0;
        endcase
        return r & mask;
    endfunction

    assign alu_res8  = 8'(alu_ref(alu_op8, {24'd0, alu_a8}, {24'd0, alu_b8}, 8));
    assign alu_res16 = 16'(alu_ref(alu_op16, {16'd0, alu_a16}, {16'd0, alu_b16}, 16));

    uart_alu_cmd_ctrl #(.DATA_WIDTH(8), .TIMEOUT_CLKS(TO_CLKS), .ERR_CODE(8'hEE)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done8), .i_rx_data(rx_data8),
        .i_tx_done(tx_done8), .o_tx_start(tx_start8), .o_tx_data(tx_data8),
        .o_alu_a(alu_a8), .o_alu_b(alu_b8), .o_alu_op(alu_op8), .i_alu_result(alu_res8),
        .o_busy(busy8), .o_err_op(err_op8), .o_timeout(timeout8)
    );

    uart_alu_cmd_ctrl #(.DATA_WIDTH(16), .TIMEOUT_CLKS(TO_CLKS), .ERR_CODE(8'hEE)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done16), .i_rx_data(rx_data16),
        .i_tx_done(tx_done16), .o_tx_start(tx_start16), .o_tx_data(tx_data16),
        .o_alu_a(alu_a16), .o_alu_b(alu_b16), .o_alu_op(alu_op16), .i_alu_result(alu_res16),
        .o_busy(busy16), .o_err_op(err_op16), .o_timeout(timeout16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // TX model + scoreboard for the 8-bit instance: answers each start with tx_done TX_GAP cycles later
    always @(negedge clk) begin
        tx_done8 = 1'b0;
        if (timeout8) to_seen8++;
        if (tx_start8) begin
            cnt8 = TX_GAP;
            checks++;
            if (exp8.size() == 0) begin
                failures++;
                $display("FAIL tx8_unexpected got=%02h required=no_tx", tx_data8);
            end else begin
                e8 = exp8.pop_front();
                $display("tx8 byte got=%02h required=%02h", tx_data8, e8);
                if (tx_data8 !== e8) begin
                    failures++;
                    $display("FAIL tx8_data got=%02h required=%02h", tx_data8, e8);
                end
            end
            checks++;
            if (cyc - last8 < TX_GAP + 1) begin
                failures++;
                $display("FAIL tx8_gap got=%0d required>=%0d", cyc - last8, TX_GAP + 1);
            end
            last8 = cyc;
        end else if (cnt8 > 0) begin
            cnt8--;
            if (cnt8 == 0) tx_done8 = 1'b1;
        end
    end

    always @(negedge clk) begin
        tx_done16 = 1'b0;
        if (tx_start16) begin
            cnt16 = TX_GAP;
            checks++;
            if (exp16.size() == 0) begin
                failures++;
                $display("FAIL tx16_unexpected got=%02h required=no_tx", tx_data16);
            end else begin
                e16 = exp16.pop_front();
                $display("tx16 byte got=%02h required=%02h", tx_data16, e16);
                if (tx_data16 !== e16) begin
                    failures++;
                    $display("FAIL tx16_data got=%02h required=%02h", tx_data16, e16);
                end
            end
            checks++;
            if (cyc - last16 < TX_GAP + 1) begin
                failures++;
                $display("FAIL tx16_gap got=%0d required>=%0d", cyc - last16, TX_GAP + 1);
            end
            last16 = cyc;
        end else if (cnt16 > 0) begin
            cnt16--;
            if (cnt16 == 0) tx_done16 = 1'b1;
        end
    end

    task automatic push_byte(input int sel, input logic [7:0] b);
        if (sel == 8) exp8.push_back(b);
        else exp16.push_back(b);
    endtask

    task automatic push_result(input int sel, input logic [15:0] r);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < sel / 8; i++) begin
            push_byte(sel, r[8*i +: 8]);
            x = x ^ r[8*i +: 8];
        end
`ifdef UART_ALU_CHECKSUM_EN
        push_byte(sel, x);
`endif
    endtask

    task automatic push_err(input int sel);
        push_byte(sel, 8'hEE);
`ifdef UART_ALU_CHECKSUM_EN
        push_byte(sel, 8'hEE);
`endif
    endtask

    task automatic send_byte(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel == 8) begin
            rx_done8 = 1'b1;
            rx_data8 = d;
        end else begin
            rx_done16 = 1'b1;
            rx_data16 = d;
        end
        @(negedge clk);
        rx_done8  = 1'b0;
        rx_done16 = 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] b);
        logic [7:0] x;
        x = op;
        send_byte(sel, op);
        for (int i = 0; i < sel / 8; i++) begin
            send_byte(sel, a[8*i +: 8]);
            x = x ^ a[8*i +: 8];
        end
        for (int i = 0; i < sel / 8; i++) begin
            send_byte(sel, b[8*i +: 8]);
            x = x ^ b[8*i +: 8];
        end
`ifdef UART_ALU_CHECKSUM_EN
        send_byte(sel, x);
`endif
    endtask

    task automatic wait_idle(input int sel, input string name);
        int n;
        n = 0;
        if (sel == 8) begin
            while ((exp8.size() != 0 || busy8) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end else begin
            while ((exp16.size() != 0 || busy16) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_idle got=busy_after_%0d required=idle", name, n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_start8, tx_data8, alu_a8, alu_b8, alu_op8, busy8, err_op8, timeout8} !== 34'd0) begin
            failures++;
            $display("FAIL reset8 got=%h required=0",
                     {tx_start8, tx_data8, alu_a8, alu_b8, alu_op8, busy8, err_op8, timeout8});
        end
        checks++;
        if ({tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, err_op16, timeout16} !== 50'd0) begin
            failures++;
            $display("FAIL reset16 got=%h required=0",
                     {tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, err_op16, timeout16});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add8;
        push_result(8, 16'h0008);
        send_frame(8, 8'h20, 16'h0005, 16'h0003);
        checks++;
        if ({alu_op8, alu_a8, alu_b8} !== {6'h20, 8'h05, 8'h03}) begin
            failures++;
            $display("FAIL add8_operands got=%h required=%h", {alu_op8, alu_a8, alu_b8},
                     {6'h20, 8'h05, 8'h03});
        end
        checks++;
        if (tx_start8 !== 1'b0 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL add8_exec got=start%b_busy%b required=start0_busy1", tx_start8, busy8);
        end
        @(negedge clk);
        checks++;
        if (tx_start8 !== 1'b1) begin
            failures++;
            $display("FAIL add8_latency got=%b required=1", tx_start8);
        end
        wait_idle(8, "add8");
    endtask

    task automatic test_sub16;
        push_result(16, 16'h1233);
        send_frame(16, 8'h22, 16'h1234, 16'h0001);
        checks++;
        if ({alu_op16, alu_a16, alu_b16} !== {6'h22, 16'h1234, 16'h0001}) begin
            failures++;
            $display("FAIL sub16_operands got=%h required=%h", {alu_op16, alu_a16, alu_b16},
                     {6'h22, 16'h1234, 16'h0001});
        end
        wait_idle(16, "sub16");
    endtask

    task automatic test_err_op;
        push_err(8);
        send_byte(8, 8'h7F);
        checks++;
        if (err_op8 !== 1'b1) begin
            failures++;
            $display("FAIL err_op_pulse got=%b required=1", err_op8);
        end
        @(negedge clk);
        checks++;
        if (err_op8 !== 1'b0) begin
            failures++;
            $display("FAIL err_op_width got=%b required=0", err_op8);
        end
        wait_idle(8, "err_op");
        push_result(8, 16'h0030);
        send_frame(8, 8'h24, 16'h00F0, 16'h003C);
        wait_idle(8, "after_err");
    endtask

    task automatic test_timeout;
        int first, width, seen0;
        first = -1;
        width = 0;
        send_byte(8, 8'h25);
        send_byte(8, 8'h0F);
        for (int j = 2; j <= 110; j++) begin
            @(negedge clk);
            if (timeout8) begin
                width++;
                if (first < 0) first = j;
            end
        end
        checks++;
        if (first != TO_CLKS + 1) begin
            failures++;
            $display("FAIL timeout_time got=%0d required=%0d", first, TO_CLKS + 1);
        end
        checks++;
        if (width != 1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got=width%0d_busy%b required=width1_busy0", width, busy8);
        end
        // Gaps just under the limit must not abort the frame
        seen0 = to_seen8;
        push_result(8, 16'h00FF);
        send_byte(8, 8'h26);
        repeat (90) @(negedge clk);
        send_byte(8, 8'h0F);
        repeat (90) @(negedge clk);
`ifdef UART_ALU_CHECKSUM_EN
        send_byte(8, 8'hF0);
        repeat (90) @(negedge clk);
        send_byte(8, 8'h26 ^ 8'h0F ^ 8'hF0);
`else
        send_byte(8, 8'hF0);
`endif
        wait_idle(8, "timeout_rearm");
        checks++;
        if (to_seen8 != seen0) begin
            failures++;
            $display("FAIL timeout_spurious got=%0d required=0", to_seen8 - seen0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ops [8];
        logic [7:0] op;
        logic [15:0] a, b, r;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        for (int k = 0; k < 8; k++) begin
            op = ops[k];
            a = 16'($urandom);
            b = (op == 8'h02 || op == 8'h03) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            r = 16'(alu_ref(op[5:0], {16'd0, a}, {16'd0, b}, 16));
            push_result(16, r);
            send_frame(16, op, a, b);
            wait_idle(16, "b2b");
        end
    endtask

    task automatic test_reset_mid_tx;
        int n;
        n = 0;
        push_byte(16, 8'h33);
        send_frame(16, 8'h22, 16'h1234, 16'h0001);
        while (!tx_start16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL rst_mid_start got=no_start required=start");
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, err_op16, timeout16} !== 50'd0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h required=0",
                     {tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, err_op16, timeout16});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (exp16.size() != 0 || busy16 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle got=q%0d_busy%b required=q0_busy0", exp16.size(), busy16);
        end
    endtask

`ifdef UART_ALU_CHECKSUM_EN
    task automatic test_checksum;
        push_byte(8, 8'hA5);
        push_byte(8, 8'hA5);
        send_byte(8, 8'h26);
        send_byte(8, 8'hAA);
        send_byte(8, 8'h0F);
        send_byte(8, 8'h83);
        wait_idle(8, "chk_good");
        push_byte(8, 8'hEE);
        push_byte(8, 8'hEE);
        send_byte(8, 8'h26);
        send_byte(8, 8'hAA);
        send_byte(8, 8'h0F);
        send_byte(8, 8'h00);
        checks++;
        if (err_op8 !== 1'b1) begin
            failures++;
            $display("FAIL chk_bad_err got=%b required=1", err_op8);
        end
        wait_idle(8, "chk_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_add8();
        test_sub16();
        test_err_op();
        test_timeout();
        test_back_to_back();
        test_reset_mid_tx();
`ifdef UART_ALU_CHECKSUM_EN
        test_checksum();
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
